muldiv_hilo_unit: RTL and testbench

Multi-cycle integer divide unit with architectural HI/LO registers for the MIPS core. It accepts DIV and DIVU requests from the decode/execute stage and runs a 32-iteration restoring division. It writes the quotient to LO and the remainder to HI, and serves MFHI/MFLO reads and MTHI/MTLO writes. It replaces the combinational divider on the execute path so the core can stall on `busy` instead of closing timing through a 32-stage ripple.

---
 rtl/muldiv_hilo_unit_if.sv | 27 ++
 rtl/muldiv_hilo_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO divide unit.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, mthi, mtlo, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, mthi, mtlo, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) owning the architectural HI/LO registers.
// Quotient lands in LO, remainder in HI; MTHI/MTLO writes are accepted only while idle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  muldiv_hilo_unit_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH:0]   r_pr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_sd;
  logic             w_sv;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_fix_hi;

  assign w_sd      = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_sv      = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_sd ? (~bus.dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.dividend;
  assign w_dvs_mag = w_sv ? (~bus.divisor + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.divisor;

  // Trial subtraction: a set borrow bit means the divisor did not fit.
  assign w_shift   = {r_pr[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_fix_lo  = r_q_neg ? (~r_q + {{(WIDTH-1){1'b0}}, 1'b1}) : r_q;
  assign w_fix_hi  = r_r_neg ? (~r_pr[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                             : r_pr[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            w_next = S_FIX;
          end else begin
            w_next = S_CALC;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pr      <= {(WIDTH+1){1'b0}};
      r_q       <= {WIDTH{1'b0}};
      r_dvs     <= {WIDTH{1'b0}};
      r_dvd_raw <= {WIDTH{1'b0}};
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_zero    <= 1'b0;
      r_cnt     <= {CW{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A divide request wins over a same-cycle move, which is dropped.
          if (bus.start) begin
            r_pr      <= {(WIDTH+1){1'b0}};
            r_q       <= w_dvd_mag;
            r_dvs     <= w_dvs_mag;
            r_dvd_raw <= bus.dividend;
            r_q_neg   <= w_sd ^ w_sv;
            r_r_neg   <= w_sd;
            r_zero    <= (bus.divisor == {WIDTH{1'b0}});
            r_cnt     <= {CW{1'b0}};
          end else begin
            if (bus.mthi) begin
              r_hi <= bus.wdata;
            end
            if (bus.mtlo) begin
              r_lo <= bus.wdata;
            end
          end
        end
        S_CALC: begin
          if (!w_trial[WIDTH]) begin
            r_pr <= w_trial;
            r_q  <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_pr <= w_shift;
            r_q  <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_zero) begin
            r_lo  <= {WIDTH{1'b1}};
            r_hi  <= r_dvd_raw;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= w_fix_lo;
            r_hi  <= w_fix_hi;
          end
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed vector table, corner sequences,
// and random operands checked against a plain-arithmetic division model.
module tb_muldiv_hilo_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: language division on wide signed/unsigned values.
  task automatic model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0]; hi = r[31:0]; dbz = 1'b0;
    end else begin
      lo = a / b; hi = a % b; dbz = 1'b0;
    end
  endtask

  task automatic wait_done(output int edges, output int busy_cyc, input bit poke);
    edges = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && edges < 100) begin
      if (poke && edges == 5) begin
        bus.start = 1'b1; bus.is_signed = 1'b0;
        bus.dividend = 32'd77; bus.divisor = 32'd0;
        bus.mtlo = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
      end else begin
        bus.start = 1'b0; bus.mtlo = 1'b0; bus.mthi = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (bus.busy) busy_cyc++;
    end
    bus.start = 1'b0; bus.mtlo = 1'b0; bus.mthi = 1'b0;
  endtask

  task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_dbz, input bit poke);
    int edges, busy_cyc, exp_lat;
    exp_lat = exp_dbz ? 1 : 33;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sg; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.is_signed = 1'($urandom_range(0, 1));
    bus.dividend = $urandom; bus.divisor = $urandom;
    wait_done(edges, busy_cyc, poke);
    check({name, ".latency"}, 32'(edges), 32'(exp_lat));
    check({name, ".busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    check({name, ".lo"}, bus.lo, exp_lo);
    check({name, ".hi"}, bus.hi, exp_hi);
    check({name, ".dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    @(posedge clk); #1;
    check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({name, ".dbz_clear"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    int edges, busy_cyc;
    logic sg;
    logic [31:0] a, b, elo, ehi;
    logic edbz;

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{"div_100_7",   1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{"div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{"div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[3] = '{"divu_max_2",  1'b0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1,         1'b0};
    vecs[4] = '{"div_m1_2",    1'b1, 32'hFFFF_FFFF, 32'd2,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{"div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    vecs[6] = '{"div_5_0",     1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
    vecs[7] = '{"divu_0_0",    1'b0, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[8] = '{"divu_7_9",    1'b0, 32'd7,         32'd9,         32'd0,         32'd7,         1'b0};

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.hi", bus.hi, 32'd0);
    check("reset.lo", bus.lo, 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.dbz", 32'(bus.div_by_zero), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].dbz, 1'b0);
    end

    // MTHI, then a simultaneous MTHI+MTLO.
    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check("mthi.hi", bus.hi, 32'h0000_ABCD);
    @(negedge clk);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthilo.hi", bus.hi, 32'hCAFE_F00D);
    check("mthilo.lo", bus.lo, 32'hCAFE_F00D);

    // start beats a same-cycle move.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
    bus.mtlo = 1'b1; bus.wdata = 32'h5555_5555;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mtlo = 1'b0;
    check("prio.lo_unchanged", bus.lo, 32'hCAFE_F00D);
    wait_done(edges, busy_cyc, 1'b0);
    check("prio.lo", bus.lo, 32'd3);
    @(posedge clk); #1;

    // Mid-CALC start/mtlo/mthi are ignored.
    do_div("ignore_busy", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);

    // Restart in the done cycle: busy goes straight back up.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd20; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(edges, busy_cyc, 1'b0);
    check("chain.first_lo", bus.lo, 32'd6);
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hFFFF_FFE2; bus.divisor = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("chain.busy", 32'(bus.busy), 32'd1);
    check("chain.done", 32'(bus.done), 32'd0);
    wait_done(edges, busy_cyc, 1'b0);
    check("chain.latency", 32'(edges), 32'd33);
    check("chain.lo", bus.lo, 32'hFFFF_FFF9);
    check("chain.hi", bus.hi, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // Reset at iteration 10 abandons the divide.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset.hi", bus.hi, 32'd0);
    check("midreset.lo", bus.lo, 32'd0);
    check("midreset.busy", 32'(bus.busy), 32'd0);
    check("midreset.dbz", 32'(bus.div_by_zero), 32'd0);
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) edges++;
    end
    check("midreset.no_done", 32'(edges), 32'd0);

    // Random operands against the model.
    for (int i = 0; i < 60; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = 32'h8000_0000;
      model(sg, a, b, elo, ehi, edbz);
      do_div($sformatf("rand%0d", i), sg, a, b, elo, ehi, edbz, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
